// File: rtl/bira_ctrl.sv
// bira_ctrl: built-in redundancy analysis controller that sorts BIST faults into pivot / non-pivot CAMs
// and sequences the external analyzer handshake.
module bira_ctrl #(
  parameter int PCAM  = 8,
  parameter int NPCAM = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] spare_struct,
  input  logic       fault_detect,
  input  logic [9:0] row_add_in,
  input  logic [9:0] col_add_in,
  input  logic [1:0] bank_in,
  input  logic       test_end,
  output logic       pcam_we,
  output logic [2:0] pcam_idx,
  output logic       npcam_we,
  output logic [4:0] npcam_idx,
  output logic [2:0] npcam_ptr,
  output logic       npcam_ptr_col,
  output logic [9:0] wr_row,
  output logic [9:0] wr_col,
  output logic [1:0] wr_bank,
  output logic       ana_start,
  input  logic       ana_done,
  input  logic       ana_repair,
  output logic       early_term,
  output logic       repair,
  output logic       done
);
  localparam logic [1:0] COLLECT = 2'd0, ANALYZE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  localparam int PW = $clog2(PCAM + 1);
  localparam int NW = $clog2(NPCAM + 1);
  localparam int IW = $clog2(PCAM);
  logic [1:0] state;
  logic [PCAM-1:0] p_val;
  logic [9:0] p_row [PCAM];
  logic [9:0] p_col [PCAM];
  logic [1:0] p_bank [PCAM];
  logic [PW-1:0] pivot_cnt, limit;
  logic [NW-1:0] npivot_cnt;
  logic [IW-1:0] slot;
  logic [3:0] raw_lim;
  logic exact, row_hit, col_hit, is_np, live, term;
  logic [2:0] row_idx, col_idx;
  assign raw_lim = spare_struct == 2'd3 ? 4'd8 : 4'd4 + {2'b00, spare_struct};
  assign limit = int'(raw_lim) > PCAM ? PW'(PCAM) : PW'(raw_lim);
  assign slot = IW'(pivot_cnt);
  // Scan high to low so the lowest matching pivot index is the one left standing.
  always_comb begin
    exact = 1'b0;
    row_hit = 1'b0;
    col_hit = 1'b0;
    row_idx = '0;
    col_idx = '0;
    for (int i = PCAM - 1; i >= 0; i--) begin
      if (p_val[i] && p_bank[i] == bank_in) begin
        if (p_row[i] == row_add_in && p_col[i] == col_add_in) exact = 1'b1;
        if (p_row[i] == row_add_in) begin
          row_hit = 1'b1;
          row_idx = 3'(i);
        end
        if (p_col[i] == col_add_in) begin
          col_hit = 1'b1;
          col_idx = 3'(i);
        end
      end
    end
  end
  assign is_np = row_hit | col_hit;
  assign live = state == COLLECT && fault_detect && !exact;
  assign term = live && (is_np ? npivot_cnt >= NW'(NPCAM) : pivot_cnt >= limit);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      p_val <= '0;
      for (int i = 0; i < PCAM; i++) begin
        p_row[i] <= '0;
        p_col[i] <= '0;
        p_bank[i] <= '0;
      end
      pivot_cnt <= '0;
      npivot_cnt <= '0;
      pcam_we <= 1'b0;
      pcam_idx <= '0;
      npcam_we <= 1'b0;
      npcam_idx <= '0;
      npcam_ptr <= '0;
      npcam_ptr_col <= 1'b0;
      wr_row <= '0;
      wr_col <= '0;
      wr_bank <= '0;
      ana_start <= 1'b0;
      early_term <= 1'b0;
      repair <= 1'b0;
      done <= 1'b0;
    end else begin
      pcam_we <= 1'b0;
      npcam_we <= 1'b0;
      ana_start <= 1'b0;
      if (state == COLLECT) begin
        if (live && !term) begin
          wr_row <= row_add_in;
          wr_col <= col_add_in;
          wr_bank <= bank_in;
          if (is_np) begin
            npcam_we <= 1'b1;
            npcam_idx <= 5'(npivot_cnt);
            npcam_ptr <= row_hit ? row_idx : col_idx;
            npcam_ptr_col <= !row_hit;
            npivot_cnt <= npivot_cnt + 1'b1;
          end else begin
            pcam_we <= 1'b1;
            pcam_idx <= 3'(pivot_cnt);
            p_val[slot] <= 1'b1;
            p_row[slot] <= row_add_in;
            p_col[slot] <= col_add_in;
            p_bank[slot] <= bank_in;
            pivot_cnt <= pivot_cnt + 1'b1;
          end
        end
        if (term) begin
          early_term <= 1'b1;
          repair <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end else if (test_end) begin
          ana_start <= 1'b1;
          state <= ANALYZE;
        end
      end else if (state == ANALYZE) begin
        state <= WAIT;
      end else if (state == WAIT && ana_done) begin
        repair <= ana_repair;
        done <= 1'b1;
        state <= DONE;
      end
    end
  end
endmodule
